qarma_round_iter: RTL
=====================

Name: qarma_round_iter

Overview:
- Iterative, parametrised QARMA round engine for the n=64 or n=128 datapath.
- Applies ROUNDS forward rounds (tau, sigma, MixColumns) or ROUNDS backward rounds to a state over several clock cycles. It instantiates UNROLL copies of the existing Round primitive in a chain, one chain pass per cycle.
- Adds a valid/ready job interface, a per-job direction select, and per-round constant injection. The design uses it in place of a fully unrolled forward or backward half-cipher.

Parameters:
- N, 128, state/tweakey width (64 or 128).
- ROUNDS, 8, rounds per job (1..16).
- UNROLL, 2, Round instances evaluated per cycle. ROUNDS mod UNROLL must be 0; elaboration fails otherwise.
- FIRST_SHORT, 1, when 1 the first round of a forward job (last round of a backward job) uses the short variant (no tau/MixColumns).
- RC, all-zero, array [0:15] of N-bit round constants; RC[i] is XORed into the tweakey of round i.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  engine can accept a job
- in_inv  in  1  0 = forward rounds, 1 = backward (inverse) rounds
- in_tk  in  N  base tweakey for the job
- in_data  in  N  initial state
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  N  final state
- busy  out  1  job in flight (RUN or DONE)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state FSM = IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, round counter=0.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_data into the state register, in_tk into the tk register, and in_inv into the mode register; clear the counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, evaluate UNROLL chained rounds and write the result to the state register.
  - The counter advances by UNROLL per cycle.
  - Forward: slot j in the cycle with count c is round i=c+j, tweakey tk^RC[i]. The short variant applies only at i=0 and only when FIRST_SHORT=1.
  - Backward: round i=c+j uses inv=1 and tweakey tk^RC[ROUNDS-1-i]. The short variant applies at i=ROUNDS-1 when FIRST_SHORT=1.
  - When c+UNROLL==ROUNDS, go to DONE and set out_valid=1 with out_data = new state.
- DONE:
  - out_valid=1 and out_data held stable until out_ready.
  - On out_valid&&out_ready, return to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency: ROUNDS/UNROLL cycles from the accept edge to the out_valid assertion. Throughput: one job per ROUNDS/UNROLL+2 cycles minimum.
- in_valid and input data are ignored while not in IDLE. out_ready is ignored outside DONE.
- Round-trip property: a forward job followed by a backward job with the same tk returns the original data.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to IDLE; the partial state is discarded.
  - out_valid drops asynchronously.
- Width rule: all XORs are N bits. The counter is clog2(ROUNDS)+1 bits wide and never wraps, because it is cleared on accept.
- busy=1 in RUN and DONE.

Test Plan:
- Reset: rst_n=0 for 3 cycles then 1 → in_ready=1, out_valid=0, busy=0, out_data=0.
- Forward job (defaults N=128, ROUNDS=8, UNROLL=2):
  - Stimulus: in_data=128'h0123456789abcdef_fedcba9876543210, in_tk=128'h0, out_ready=1.
  - Response: out_valid exactly 4 cycles after the accept edge; out_data equals the golden model of 8 forward rounds (round 0 short).
- Round-trip: take the forward result from the previous scenario and submit it with in_inv=1 and the same tk → out_data=128'h0123456789abcdef_fedcba9876543210.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, and a second in_valid is ignored.
  - Then set out_ready=1 → IDLE, and in_ready=1 one cycle later.
- Reset mid-operation: assert rst_n=0 two cycles into RUN → out_valid=0, in_ready=1 after release; a new job then completes with the correct golden result.
- Parameter sweep: ROUNDS=4/UNROLL=4 gives latency 1; ROUNDS=6/UNROLL=1 gives latency 6. Use nonzero RC and FIRST_SHORT=0 → outputs match the golden model per configuration.

Source files
------------

// File: rtl/qarma_round_iter_if.sv
// Job interface of the iterative QARMA round engine: request side (in_*),
// result side (out_*) and the busy flag.
interface qarma_round_iter_if #(
  parameter int N = 128
);
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [N-1:0] in_tk;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_inv, in_tk, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_inv, in_tk, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/qarma_round_iter.sv
// Iterative QARMA round engine: UNROLL chained rounds per cycle, forward or
// backward per job, with per-round constants folded into the tweakey.

module qarma_round #(
  parameter int N = 128
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] tk,
  input  logic         inv,
  input  logic         skip,
  output logic [N-1:0] y
);
  localparam int C = N / 16;
  localparam int TAU [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};
  // sigma is an involution, so the same table serves both directions
  localparam logic [3:0] SBOX [16] = '{4'd10, 4'd13, 4'd14, 4'd6, 4'd15, 4'd7, 4'd3, 4'd5,
                                       4'd9, 4'd8, 4'd0, 4'd12, 4'd11, 4'd1, 4'd2, 4'd4};

  function automatic logic [N-1:0] sub_cells(input logic [N-1:0] s);
    logic [N-1:0] r;
    r = '0;
    for (int b = 0; b < N / 4; b++) r[4*b +: 4] = SBOX[s[4*b +: 4]];
    return r;
  endfunction

  function automatic logic [N-1:0] tau_fwd(input logic [N-1:0] s);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[N-1-C*i -: C] = s[N-1-C*TAU[i] -: C];
    return r;
  endfunction

  function automatic logic [N-1:0] tau_inv(input logic [N-1:0] s);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[N-1-C*TAU[i] -: C] = s[N-1-C*i -: C];
    return r;
  endfunction

  function automatic logic [C-1:0] rho(input logic [C-1:0] v, input int e);
    logic [2*C-1:0] t;
    t = {v, v} << e;
    return t[2*C-1 -: C];
  endfunction

  // circulant exponents: circ(0,r,r^2,r) for 4-bit cells, circ(0,r,r^4,r^5) for 8-bit
  function automatic int mexp(input int d);
    if (N == 64) return (d == 2) ? 2 : 1;
    return (d == 1) ? 1 : (d == 2) ? 4 : 5;
  endfunction

  // both matrices are involutory, so MixColumns is its own inverse
  function automatic logic [N-1:0] mix(input logic [N-1:0] s);
    logic [N-1:0] r;
    logic [C-1:0] acc;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          if (k != row) acc = acc ^ rho(s[N-1-C*(4*k+col) -: C], mexp((k - row) & 3));
        r[N-1-C*(4*row+col) -: C] = acc;
      end
    end
    return r;
  endfunction

  always_comb begin
    logic [N-1:0] v;
    if (!inv) begin
      v = x ^ tk;
      if (!skip) v = mix(tau_fwd(v));
      y = sub_cells(v);
    end else begin
      v = sub_cells(x);
      if (!skip) v = tau_inv(mix(v));
      y = v ^ tk;
    end
  end
endmodule

module qarma_round_iter #(
  parameter int           N           = 128,
  parameter int           ROUNDS      = 8,
  parameter int           UNROLL      = 2,
  parameter int           FIRST_SHORT = 1,
  parameter logic [N-1:0] RC [0:15]   = '{default: '0}
) (
  input logic              clk,
  input logic              rst_n,
  qarma_round_iter_if.slave bus
);
  localparam int CW = $clog2(ROUNDS) + 1;

  if ((N != 64 && N != 128) || ROUNDS < 1 || ROUNDS > 16 || UNROLL < 1
      || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("qarma_round_iter: unsupported N/ROUNDS/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st, st_nxt;

  logic [CW-1:0] cnt;
  logic          mode;
  logic [N-1:0]  tk;
  logic [N-1:0]  state;
  logic [N-1:0]  out_q;
  logic [N-1:0]  chain [0:UNROLL];
  logic          accept;
  logic          last;

  assign accept   = (st == IDLE) && bus.in_valid;
  assign last     = (cnt + CW'(UNROLL)) == CW'(ROUNDS);
  assign chain[0] = state;

  for (genvar j = 0; j < UNROLL; j++) begin : g_slot
    logic [CW:0] rnd;
    logic [3:0]  ridx;
    logic        skip;
    always_comb begin
      rnd  = {1'b0, cnt} + (CW+1)'(j);
      ridx = mode ? 4'(ROUNDS - 1 - int'(rnd)) : 4'(rnd);
      skip = (FIRST_SHORT != 0) && (mode ? (int'(rnd) == ROUNDS - 1) : (rnd == '0));
    end
    qarma_round #(.N(N)) u_round (
      .x   (chain[j]),
      .tk  (tk ^ RC[ridx]),
      .inv (mode),
      .skip(skip),
      .y   (chain[j+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.in_valid) st_nxt = RUN;
      RUN:     if (last) st_nxt = DONE;
      DONE:    if (bus.out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (st)
      IDLE:    bus.in_ready = 1'b1;
      RUN:     bus.busy = 1'b1;
      DONE:    begin bus.out_valid = 1'b1; bus.busy = 1'b1; end
      default: bus.in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      out_q <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (st == RUN) begin
      cnt <= cnt + CW'(UNROLL);
      if (last) out_q <= chain[UNROLL];
    end
  end

  // job operands and the working state carry no reset; a job always reloads them
  always_ff @(posedge clk) begin
    if (accept) begin
      state <= bus.in_data;
      tk    <= bus.in_tk;
      mode  <= bus.in_inv;
    end else if (st == RUN) begin
      state <= chain[UNROLL];
    end
  end

  assign bus.out_data = out_q;
endmodule
